alt_vipitc120_mode_commit: RTL and testbench

- Parametrised successor to the ITC one-hot-to-binary mode converter.
- Registers the per-mode match vector and priority-encodes it to a 1-based binary mode code (0 = no mode).
- Qualifies a new code for STABLE_CYCLES consecutive clocks, then commits it only on a start-of-frame boundary.
- Sits between the mode-match comparators and the ITC timing generator; mode switches never tear a frame.

---
 rtl/alt_vipitc120_common_pkg.sv | 18 +
 rtl/alt_vipitc120_common_priority_encoder.sv | 28 ++
 rtl/alt_vipitc120_mode_commit.sv | 124 ++++++++++++
 tb/tb_alt_vipitc120_mode_commit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alt_vipitc120_common_pkg.sv
// Shared ITC mode-commit definitions: FSM encodings, priority constants, width check.
package alt_vipitc120_common_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_PENDING = 2'd2
    } mode_state_t;

    localparam int PRIO_LOW  = 0;
    localparam int PRIO_HIGH = 1;

    // The code must express every mode index+1 as well as the reserved zero code.
    function automatic bit code_width_ok(input int modes, input int width);
        return (2 ** width) > modes;
    endfunction

endpackage

// File: rtl/alt_vipitc120_common_priority_encoder.sv
// One-hot (possibly multi-hot) to 1-based binary code; 0 when no bit is set.
module alt_vipitc120_common_priority_encoder
    import alt_vipitc120_common_pkg::*;
#(
    parameter int NO_OF_MODES      = 3,
    parameter int LOG2_NO_OF_MODES = 2,
    parameter int PRIORITY_HIGH    = PRIO_LOW
) (
    input  logic [NO_OF_MODES-1:0]      one_hot,
    output logic [LOG2_NO_OF_MODES-1:0] code,
    output logic                        multi_hot
);

    // Later loop iterations overwrite earlier ones, so scan direction picks the winner.
    always_comb begin
        code = '0;
        if (PRIORITY_HIGH == PRIO_HIGH) begin
            for (int i = 0; i < NO_OF_MODES; i++)
                if (one_hot[i]) code = LOG2_NO_OF_MODES'(i + 1);
        end else begin
            for (int i = NO_OF_MODES - 1; i >= 0; i--)
                if (one_hot[i]) code = LOG2_NO_OF_MODES'(i + 1);
        end
    end

    assign multi_hot = ($countones(one_hot) > 1);

endmodule

// File: rtl/alt_vipitc120_mode_commit.sv
// Registers mode-match flags, qualifies a new mode code for STABLE_CYCLES and commits it on sof.
module alt_vipitc120_mode_commit
    import alt_vipitc120_common_pkg::*;
#(
    parameter int NO_OF_MODES      = 3,
    parameter int LOG2_NO_OF_MODES = 2,
    parameter int STABLE_CYCLES    = 4,
    parameter int STABLE_CNT_WIDTH = 3,
    parameter int PRIORITY_HIGH    = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NO_OF_MODES-1:0]      one_hot,
    input  logic                        one_hot_valid,
    input  logic                        sof,
    output logic [LOG2_NO_OF_MODES-1:0] binary,
    output logic                        binary_valid,
    output logic                        mode_change,
    output logic                        pending,
    output logic                        multi_hot_err
);

    localparam logic [STABLE_CNT_WIDTH-1:0] CNT_ONE  = STABLE_CNT_WIDTH'(1);
    localparam logic [STABLE_CNT_WIDTH-1:0] CNT_DONE = STABLE_CNT_WIDTH'(STABLE_CYCLES);

    generate
        if (!code_width_ok(NO_OF_MODES, LOG2_NO_OF_MODES)) begin : g_bad_code_width
            $error("LOG2_NO_OF_MODES too narrow for NO_OF_MODES");
        end
        if (STABLE_CYCLES < 1 || !code_width_ok(STABLE_CYCLES - 1, STABLE_CNT_WIDTH)) begin : g_bad_cnt_width
            $error("STABLE_CYCLES out of range for STABLE_CNT_WIDTH");
        end
    endgenerate

    logic [NO_OF_MODES-1:0]      in_reg;
    logic [LOG2_NO_OF_MODES-1:0] cand;
    logic [LOG2_NO_OF_MODES-1:0] track_code;
    logic [LOG2_NO_OF_MODES-1:0] pending_code;
    logic [STABLE_CNT_WIDTH-1:0] cnt;
    mode_state_t                 state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             in_reg <= '0;
        else if (one_hot_valid) in_reg <= one_hot;
    end

    // multi_hot_err is a pure function of in_reg, so it tracks the register exactly.
    alt_vipitc120_common_priority_encoder #(
        .NO_OF_MODES      (NO_OF_MODES),
        .LOG2_NO_OF_MODES (LOG2_NO_OF_MODES),
        .PRIORITY_HIGH    (PRIORITY_HIGH)
    ) u_enc (
        .one_hot   (in_reg),
        .code      (cand),
        .multi_hot (multi_hot_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            track_code   <= '0;
            pending_code <= '0;
            binary       <= '0;
            mode_change  <= 1'b0;
            pending      <= 1'b0;
        end else begin
            mode_change <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cand != binary) begin
                        state      <= ST_QUALIFY;
                        cnt        <= CNT_ONE;
                        track_code <= cand;
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_QUALIFY: begin
                    if (cand == binary) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cand != track_code) begin
                        cnt        <= CNT_ONE;
                        track_code <= cand;
                    end else if (cnt == CNT_DONE) begin
                        state        <= ST_PENDING;
                        pending_code <= track_code;
                        pending      <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_PENDING: begin
                    // A frame boundary commits even if the input moved this cycle.
                    if (sof) begin
                        binary      <= pending_code;
                        mode_change <= 1'b1;
                        pending     <= 1'b0;
                        state       <= ST_IDLE;
                        cnt         <= '0;
                    end else if (cand != pending_code) begin
                        pending <= 1'b0;
                        if (cand == binary) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else begin
                            state      <= ST_QUALIFY;
                            cnt        <= CNT_ONE;
                            track_code <= cand;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign binary_valid = (binary != '0);

endmodule

// File: tb/tb_alt_vipitc120_mode_commit.sv
// Bench for alt_vipitc120_mode_commit: lowest- and highest-priority instances against a run-length model.
module tb_alt_vipitc120_mode_commit;

    localparam int N  = 3;
    localparam int W  = 2;
    localparam int S  = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] one_hot = '0;
    logic one_hot_valid = 1'b0;
    logic sof = 1'b0;

    logic [1:0][W-1:0] binary;
    logic [1:0] binary_valid, mode_change, pending, multi_hot_err;

    always #5 clk = ~clk;

    alt_vipitc120_mode_commit #(
        .NO_OF_MODES(N), .LOG2_NO_OF_MODES(W), .STABLE_CYCLES(S),
        .STABLE_CNT_WIDTH(CW), .PRIORITY_HIGH(0)
    ) u_dut_lo (
        .clk(clk), .rst_n(rst_n), .one_hot(one_hot), .one_hot_valid(one_hot_valid), .sof(sof),
        .binary(binary[0]), .binary_valid(binary_valid[0]), .mode_change(mode_change[0]),
        .pending(pending[0]), .multi_hot_err(multi_hot_err[0])
    );

    alt_vipitc120_mode_commit #(
        .NO_OF_MODES(N), .LOG2_NO_OF_MODES(W), .STABLE_CYCLES(S),
        .STABLE_CNT_WIDTH(CW), .PRIORITY_HIGH(1)
    ) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .one_hot(one_hot), .one_hot_valid(one_hot_valid), .sof(sof),
        .binary(binary[1]), .binary_valid(binary_valid[1]), .mode_change(mode_change[1]),
        .pending(pending[1]), .multi_hot_err(multi_hot_err[1])
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: a code is committed once it has been seen for S+1 consecutive edges
    // (differing from the committed code) and then a sof is sampled.
    logic [N-1:0] m_reg;
    int  m_bin[2], m_run[2], m_last[2], m_pcode[2];
    bit  m_pend[2], m_mc[2];
    int  m_mc_cnt[2], d_mc_cnt[2];

    function automatic int enc(input logic [N-1:0] v, input int hi);
        int r = 0;
        for (int i = 0; i < N; i++)
            if (v[i] && (hi != 0 || r == 0)) r = i + 1;
        return r;
    endfunction

    task automatic model_reset();
        m_reg = '0;
        for (int p = 0; p < 2; p++) begin
            m_bin[p] = 0; m_run[p] = 0; m_last[p] = 0;
            m_pcode[p] = 0; m_pend[p] = 0; m_mc[p] = 0;
        end
    endtask

    task automatic model_step(input logic [N-1:0] oh, input logic v, input logic s);
        for (int p = 0; p < 2; p++) begin
            int c;
            c = enc(m_reg, p);
            m_mc[p] = 0;
            if (m_pend[p]) begin
                if (s) begin
                    m_bin[p] = m_pcode[p]; m_mc[p] = 1; m_mc_cnt[p]++;
                    m_pend[p] = 0; m_run[p] = 0;
                end else if (c != m_pcode[p]) begin
                    m_pend[p] = 0;
                    m_run[p]  = (c != m_bin[p]) ? 1 : 0;
                    m_last[p] = c;
                end
            end else if (c == m_bin[p]) begin
                m_run[p] = 0;
            end else begin
                m_run[p]  = (m_run[p] > 0 && c == m_last[p]) ? m_run[p] + 1 : 1;
                m_last[p] = c;
                if (m_run[p] == S + 1) begin
                    m_pend[p] = 1; m_pcode[p] = c;
                end
            end
        end
        if (v) m_reg = oh;
    endtask

    task automatic check_all(input string tag);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s_p%0d_binary", tag, p), 32'(binary[p]), 32'(m_bin[p]));
            chk($sformatf("%s_p%0d_binary_valid", tag, p), 32'(binary_valid[p]), 32'(m_bin[p] != 0));
            chk($sformatf("%s_p%0d_pending", tag, p), 32'(pending[p]), 32'(m_pend[p]));
            chk($sformatf("%s_p%0d_mode_change", tag, p), 32'(mode_change[p]), 32'(m_mc[p]));
            chk($sformatf("%s_p%0d_multi_hot_err", tag, p), 32'(multi_hot_err[p]),
                32'($countones(m_reg) > 1));
            if (mode_change[p]) d_mc_cnt[p]++;
        end
    endtask

    int cyc = 0;

    task automatic step(input logic [N-1:0] oh, input logic v, input logic s);
        one_hot = oh; one_hot_valid = v; sof = s;
        model_step(oh, v, s);
        @(posedge clk);
        #1;
        cyc++;
        check_all($sformatf("cyc%0d", cyc));
    endtask

    initial begin
        int mc_edge, pend_edge;
        logic [N-1:0] roh;

        for (int p = 0; p < 2; p++) begin m_mc_cnt[p] = 0; d_mc_cnt[p] = 0; end
        #1;
        model_reset();
        check_all("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // First commit with sof held high: pending at edge S+1, commit at S+2.
        mc_edge = -1; pend_edge = -1;
        step(3'b010, 1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step(3'b010, 1'b0, 1'b1);
            if (pending[0] && pend_edge < 0) pend_edge = k;
            if (mode_change[0] && mc_edge < 0) mc_edge = k;
        end
        chk("latency_pending_edge", 32'(pend_edge), 32'(S + 1));
        chk("latency_mode_change_edge", 32'(mc_edge), 32'(S + 2));
        chk("first_commit_binary", 32'(binary[0]), 32'd2);

        // Long-stable code waits for a late sof.
        step(3'b100, 1'b1, 1'b0);
        repeat (19) step(3'b100, 1'b0, 1'b0);
        step(3'b100, 1'b0, 1'b1);
        repeat (3) step(3'b100, 1'b0, 1'b0);
        chk("late_sof_binary", 32'(binary[0]), 32'd3);

        // Short glitch back to the committed code never reaches pending.
        step(3'b001, 1'b1, 1'b0);
        step(3'b001, 1'b0, 1'b0);
        step(3'b100, 1'b1, 1'b0);
        repeat (8) step(3'b100, 1'b0, 1'b1);
        chk("glitch_binary", 32'(binary[0]), 32'd3);

        // Multi-hot: low-priority instance moves to 2, high-priority stays at 3.
        step(3'b110, 1'b1, 1'b0);
        repeat (6) step(3'b110, 1'b0, 1'b0);
        step(3'b110, 1'b0, 1'b1);
        repeat (2) step(3'b110, 1'b0, 1'b0);
        chk("multihot_lo_binary", 32'(binary[0]), 32'd2);
        chk("multihot_hi_binary", 32'(binary[1]), 32'd3);

        // sof in the same cycle the input moves: the pending code still commits.
        step(3'b001, 1'b1, 1'b0);
        repeat (5) step(3'b001, 1'b0, 1'b0);
        step(3'b100, 1'b1, 1'b0);
        step(3'b100, 1'b0, 1'b1);
        chk("race_commit_binary", 32'(binary[0]), 32'd1);
        repeat (6) step(3'b100, 1'b0, 1'b0);
        step(3'b100, 1'b0, 1'b1);
        step(3'b100, 1'b0, 1'b0);
        chk("race_requalify_binary", 32'(binary[0]), 32'd3);

        // Asynchronous reset while pending.
        step(3'b010, 1'b1, 1'b0);
        repeat (5) step(3'b010, 1'b0, 1'b0);
        chk("pre_reset_pending", 32'(pending[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) step(3'b000, 1'b0, 1'b1);

        // Randomized phase.
        for (int it = 0; it < 120; it++) begin
            int hold;
            roh  = N'($urandom_range(0, 7));
            hold = $urandom_range(1, 10);
            for (int h = 0; h < hold; h++)
                step(roh, ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0));
        end

        for (int p = 0; p < 2; p++)
            chk($sformatf("p%0d_mode_change_count", p), 32'(d_mc_cnt[p]), 32'(m_mc_cnt[p]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
